// File: rtl/sound_pkg.sv
// Shared constants and types for the sound output path: sample/frame widths,
// mix offset and scaling, and the DC-blocking filter shift.
package sound_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_W     = 32;
  localparam int BIT_CNT_W   = $clog2(FRAME_W);
  localparam int MIX_OFFSET  = 240;
  localparam int SCALE_SHIFT = 6;
  localparam int HPF_SHIFT   = 8;
  localparam int HPF_ACC_W   = 18;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Left occupies the upper half so it is shifted out first.
  typedef struct packed {
    sample_t l;
    sample_t r;
  } frame_t;

endpackage

// File: rtl/sound_i2s_tx.sv
// I2S transmitter: BCLK/LRCK generation, 32-bit frame shifter with the
// standard one-bit data delay, and the per-frame sample strobe.
module sound_i2s_tx
  import sound_pkg::*;
#(
  parameter int BCLK_DIV = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  frame_t frame,
  output logic   frame_load,
  output logic   i2s_bclk,
  output logic   i2s_lrck,
  output logic   i2s_sdata,
  output logic   sample_strobe
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt;
  logic [FRAME_W-1:0]   shreg;
  logic                 div_term;
  logic                 bclk_fall;

  always_comb begin
    div_term    = (div_cnt == DIV_LAST);
    bclk_fall   = div_term && i2s_bclk;
    bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
    frame_load  = bclk_fall && (bit_cnt == '1);
  end

  // Data leaves from the top of the shifter, so the bit emitted on the load
  // edge is the last bit of the previous frame (one-slot I2S delay).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt       <= '0;
      i2s_bclk      <= 1'b0;
      bit_cnt       <= '1;
      i2s_lrck      <= 1'b0;
      i2s_sdata     <= 1'b0;
      shreg         <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_load;
      if (div_term) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (bclk_fall) begin
        bit_cnt   <= bit_cnt_nxt;
        i2s_lrck  <= bit_cnt_nxt[BIT_CNT_W-1];
        i2s_sdata <= shreg[FRAME_W-1];
        shreg     <= frame_load ? frame : {shreg[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/sound_mixer_i2s.sv
// Final channel mixer (NR51 panning, NR50 volume, NR52 master) feeding the I2S
// transmitter. Define SOUND_HPF_EN to add a per-side DC-blocking filter.
module sound_mixer_i2s
  import sound_pkg::*;
#(
  parameter int BCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ch_level,
  input  logic [3:0]  ch_enable,
  input  logic [7:0]  nr50,
  input  logic [7:0]  nr51,
  input  logic        master_en,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        sample_strobe
);

  // Sum routed channels (0..60), scale by vol+1 (0..480), centre and widen.
  function automatic sample_t mix_side(input logic [15:0] lvl,
                                       input logic [3:0]  en,
                                       input logic [3:0]  route,
                                       input logic [2:0]  vol);
    logic [5:0]        sum;
    logic [8:0]        scaled;
    logic signed [9:0] centered;
    sample_t           wide;
    sum = '0;
    for (int n = 0; n < 4; n++) begin
      if (en[n] && route[n]) sum = sum + 6'(lvl[4*n +: 4]);
    end
    scaled   = 9'(sum) * (9'(vol) + 9'd1);
    centered = $signed({1'b0, scaled}) - $signed(10'(MIX_OFFSET));
    wide     = {{(SAMPLE_W-10){centered[9]}}, centered};
    return wide <<< SCALE_SHIFT;
  endfunction

  sample_t sample_l_p0;
  sample_t sample_r_p0;
  frame_t  frame;
  logic    frame_load;

  // Stage p0: registered mix, forced to silence when the master is off.
  always_ff @(posedge clk) begin
    if (rst || !master_en) begin
      sample_l_p0 <= '0;
      sample_r_p0 <= '0;
    end else begin
      sample_l_p0 <= mix_side(ch_level, ch_enable, nr51[7:4], nr50[6:4]);
      sample_r_p0 <= mix_side(ch_level, ch_enable, nr51[3:0], nr50[2:0]);
    end
  end

`ifdef SOUND_HPF_EN
  localparam logic signed [HPF_ACC_W-1:0] ACC_MAX = HPF_ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [HPF_ACC_W-1:0] ACC_MIN = -ACC_MAX - HPF_ACC_W'(1);

  function automatic sample_t sat_sample(input logic signed [HPF_ACC_W-1:0] acc);
    if (acc > ACC_MAX) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    if (acc < ACC_MIN) return {1'b1, {(SAMPLE_W-1){1'b0}}};
    return acc[SAMPLE_W-1:0];
  endfunction

  function automatic sample_t hpf_step(input sample_t x, input sample_t x_prev,
                                       input sample_t y_prev);
    logic signed [HPF_ACC_W-1:0] xe;
    logic signed [HPF_ACC_W-1:0] xpe;
    logic signed [HPF_ACC_W-1:0] ype;
    logic signed [HPF_ACC_W-1:0] acc;
    xe  = {{(HPF_ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    xpe = {{(HPF_ACC_W-SAMPLE_W){x_prev[SAMPLE_W-1]}}, x_prev};
    ype = {{(HPF_ACC_W-SAMPLE_W){y_prev[SAMPLE_W-1]}}, y_prev};
    acc = xe - xpe + ype - (ype >>> HPF_SHIFT);
    return sat_sample(acc);
  endfunction

  sample_t hpf_x_l, hpf_x_r;
  sample_t hpf_y_l, hpf_y_r;
  sample_t filt_l, filt_r;

  // Filter output is combinational so it lands in the frame it was computed for.
  always_comb begin
    filt_l = hpf_step(sample_l_p0, hpf_x_l, hpf_y_l);
    filt_r = hpf_step(sample_r_p0, hpf_x_r, hpf_y_r);
  end

  assign frame = {filt_l, filt_r};

  always_ff @(posedge clk) begin
    if (rst || !master_en) begin
      hpf_x_l <= '0;
      hpf_x_r <= '0;
      hpf_y_l <= '0;
      hpf_y_r <= '0;
    end else if (frame_load) begin
      hpf_x_l <= sample_l_p0;
      hpf_x_r <= sample_r_p0;
      hpf_y_l <= filt_l;
      hpf_y_r <= filt_r;
    end
  end
`else
  logic unused_frame_load;

  assign frame             = {sample_l_p0, sample_r_p0};
  assign unused_frame_load = frame_load;
`endif

  sound_i2s_tx #(
    .BCLK_DIV (BCLK_DIV)
  ) u_tx (
    .clk           (clk),
    .rst           (rst),
    .frame         (frame),
    .frame_load    (frame_load),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrck      (i2s_lrck),
    .i2s_sdata     (i2s_sdata),
    .sample_strobe (sample_strobe)
  );

endmodule

// File: tb/tb_sound_mixer_i2s.sv
// Directed bench for sound_mixer_i2s: reset/restart timing, mix values,
// frame integrity across input changes, master disable and mid-frame reset.
module tb_sound_mixer_i2s;

`ifdef SOUND_HPF_EN
  localparam int BCLK_DIV = 1;
`else
  localparam int BCLK_DIV = 2;
`endif
  localparam int SLOT = 2 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ch_level = '0;
  logic [3:0]  ch_enable = '0;
  logic [7:0]  nr50 = '0;
  logic [7:0]  nr51 = '0;
  logic        master_en = 1'b0;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        sample_strobe;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sound_mixer_i2s #(
    .BCLK_DIV (BCLK_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_level      (ch_level),
    .ch_enable     (ch_enable),
    .nr50          (nr50),
    .nr51          (nr51),
    .master_en     (master_en),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrck      (i2s_lrck),
    .i2s_sdata     (i2s_sdata),
    .sample_strobe (sample_strobe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the clk right after the next frame latch (slot 0).
  task automatic sync_strobe();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (sample_strobe === 1'b1) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL strobe_timeout: got no sample_strobe, required one within 300 clk");
    end
  endtask

  // From slot 0 of a frame, collect slots 1..31 and slot 0 of the next frame.
  task automatic read_frame(output logic [31:0] f);
    logic exp_lr;
    f = '0;
    for (int k = 1; k < 32; k++) begin
      repeat (SLOT) tick();
      f[32-k] = i2s_sdata;
      exp_lr = (k >= 16);
      n_vec++;
      if (i2s_lrck !== exp_lr || sample_strobe !== 1'b0) begin
        n_bad++;
        $display("FAIL slot%0d lrck/strobe: got %b/%b required %b/0", k, i2s_lrck,
                 sample_strobe, exp_lr);
      end
    end
    repeat (SLOT) tick();
    f[0] = i2s_sdata;
    n_vec++;
    if (sample_strobe !== 1'b1 || i2s_lrck !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_wrap strobe/lrck: got %b/%b required 1/0", sample_strobe, i2s_lrck);
    end
  endtask

  task automatic check_idle(input string tag);
    n_vec++;
    if ({i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe} !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s bclk/lrck/sdata/strobe: got %b%b%b%b required 0000", tag,
               i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe);
    end
  endtask

  // Expects rst high on the previous edge; releases it and checks every clk of
  // the first frame: BCLK edges, the first latch strobe and the LRCK halves.
  task automatic test_restart();
    logic exp_b, exp_s, exp_l;
    rst = 1'b0;
    for (int k = 1; k < 66 * BCLK_DIV; k++) begin
      tick();
      exp_b = ((k / BCLK_DIV) % 2) == 1;
      exp_s = (k == 2 * BCLK_DIV);
      exp_l = (k >= 34 * BCLK_DIV);
      n_vec++;
      if (i2s_bclk !== exp_b || sample_strobe !== exp_s || i2s_lrck !== exp_l) begin
        n_bad++;
        $display("FAIL restart clk%0d bclk/strobe/lrck: got %b%b%b required %b%b%b", k,
                 i2s_bclk, sample_strobe, i2s_lrck, exp_b, exp_s, exp_l);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_level = 16'hFFFF; ch_enable = 4'hF; nr50 = 8'h77; nr51 = 8'hFF; master_en = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    test_restart();
  endtask

  task automatic test_single_channel();
    logic [31:0] f;
    ch_level = 16'h000F; ch_enable = 4'h1; nr51 = 8'h11; nr50 = 8'h77; master_en = 1'b1;
    tick();
    sync_strobe();
    read_frame(f);
    n_vec++;
    if (f !== 32'hE200_E200) begin
      n_bad++;
      $display("FAIL single_ch frame: got %h required e200e200", f);
    end
  endtask

  task automatic test_full_mix();
    logic [31:0] f;
    ch_level = 16'hFFFF; ch_enable = 4'hF; nr51 = 8'hFF; nr50 = 8'h70;
    tick();
    sync_strobe();
    read_frame(f);
    n_vec++;
    if (f[31:16] !== 16'h3C00) begin
      n_bad++;
      $display("FAIL full_mix L: got %h required 3c00", f[31:16]);
    end
    n_vec++;
    if (f[15:0] !== 16'hD300) begin
      n_bad++;
      $display("FAIL full_mix R: got %h required d300", f[15:0]);
    end
  endtask

  task automatic test_master_off();
    logic [31:0] f0, f1, f2;
    ch_enable = 4'h0; nr50 = 8'h77; master_en = 1'b1;
    tick();
    sync_strobe();
    read_frame(f0);
    n_vec++;
    if (f0 !== 32'hC400_C400) begin
      n_bad++;
      $display("FAIL silence frame: got %h required c400c400", f0);
    end
    fork
      read_frame(f1);
      begin
        repeat (10 * SLOT + 1) tick();
        master_en = 1'b0;
      end
    join
    n_vec++;
    if (f1 !== 32'hC400_C400) begin
      n_bad++;
      $display("FAIL master_drop current frame: got %h required c400c400", f1);
    end
    read_frame(f2);
    n_vec++;
    if (f2 !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL master_off frame: got %h required 00000000", f2);
    end
  endtask

  task automatic test_back_to_back_change();
    logic [31:0] f1, f2;
    ch_level = 16'h000F; ch_enable = 4'h1; nr51 = 8'h11; nr50 = 8'h77; master_en = 1'b1;
    tick();
    sync_strobe();
    fork
      read_frame(f1);
      begin
        repeat (3 * SLOT + 1) tick();
        ch_level = 16'h0005;
      end
    join
    n_vec++;
    if (f1 !== 32'hE200_E200) begin
      n_bad++;
      $display("FAIL midframe current frame: got %h required e200e200", f1);
    end
    read_frame(f2);
    n_vec++;
    if (f2 !== 32'hCE00_CE00) begin
      n_bad++;
      $display("FAIL midframe next frame: got %h required ce00ce00", f2);
    end
  endtask

  // Frame C440/C440 puts a 1 in slot 10; reset lands while BCLK is high there.
  task automatic test_reset_midframe();
    ch_level = 16'h0001; ch_enable = 4'h1; nr51 = 8'h11; nr50 = 8'h00; master_en = 1'b1;
    tick();
    sync_strobe();
    repeat (10 * SLOT + BCLK_DIV) tick();
    n_vec++;
    if (i2s_bclk !== 1'b1 || i2s_sdata !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset bclk/sdata: got %b/%b required 1/1", i2s_bclk, i2s_sdata);
    end
    rst = 1'b1;
    tick();
    check_idle("midframe_reset");
    test_restart();
  endtask

`ifdef SOUND_HPF_EN
  task automatic test_hpf();
    logic [31:0]       f;
    logic signed [15:0] sl;
    int                mag, mag_prev;
    ch_enable = 4'h0; nr50 = 8'h77; master_en = 1'b0;
    repeat (4) tick();
    master_en = 1'b1;
    tick();
    sync_strobe();
    read_frame(f);
    n_vec++;
    if (f !== 32'hC400_C400) begin
      n_bad++;
      $display("FAIL hpf first frame: got %h required c400c400", f);
    end
    mag_prev = 15360;
    for (int n = 1; n < 1000; n++) begin
      read_frame(f);
      sl  = f[31:16];
      mag = (sl < 0) ? -int'(sl) : int'(sl);
      n_vec++;
      if (!(mag < mag_prev) || f[15:0] !== f[31:16]) begin
        n_bad++;
        $display("FAIL hpf frame%0d: got %h magnitude %0d, required magnitude below %0d and L==R",
                 n, f, mag, mag_prev);
      end
      mag_prev = mag;
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SOUND_HPF_EN
    test_hpf();
`else
    test_single_channel();
    test_full_mix();
    test_master_off();
    test_back_to_back_change();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
